data_memory_wait: RTL and testbench

- Word-organised data RAM with a programmable wait-state sequencer, sitting directly downstream of the MEM-stage memory controller.
- Consumes the controller's level-held request (Address, MWriteData, WriteEnable[3:0], ReadEnable) and returns MReadData plus a one-cycle DataMem_Ack pulse.
- Models a multi-cycle data memory so that stall and RW-mask behaviour upstream is exercised.

---
 rtl/data_memory_wait.sv | 139 +++++++++++++
 tb/tb_data_memory_wait.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_wait.sv
// Word-organised data RAM behind a wait-state sequencer (IDLE -> BUSY -> ACK).
// Define DMEM_RANGE_CHECK_EN to add DataMem_Err and suppress out-of-range accesses.
module data_memory_wait #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_STATES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Address,
    input  logic [31:0] MWriteData,
    input  logic [3:0]  WriteEnable,
    input  logic        ReadEnable,
    output logic [31:0] MReadData,
`ifdef DMEM_RANGE_CHECK_EN
    output logic        DataMem_Err,
`endif
    output logic        DataMem_Ack
);
    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [3:0]            we_q;
    logic [31:0]           wdata_q;
    logic                  re_q;
    logic                  oob_q;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q;

    logic [31:0] mem [Depth];

    logic                  req, capture, access, in_oob;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [3:0]            acc_we;
    logic [31:0]           acc_wdata;
    logic                  acc_re, acc_oob;
    logic                  unused_bits;

    assign req = ReadEnable | (|WriteEnable);

`ifdef DMEM_RANGE_CHECK_EN
    assign in_oob      = |Address[31:DEPTH_LOG2+2];
    assign DataMem_Err = err_q;
`else
    assign in_oob      = 1'b0;
`endif
    // Lane selection is upstream's job; high bits only matter to the range check.
    assign unused_bits = ^{Address[31:DEPTH_LOG2+2], Address[1:0], err_q};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= access & acc_oob;
        end
    end

    always_ff @(posedge CLK) begin
        if (capture) begin
            idx_q   <= Address[DEPTH_LOG2+1:2];
            we_q    <= WriteEnable;
            wdata_q <= MWriteData;
            re_q    <= ReadEnable;
            oob_q   <= in_oob;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        access  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        access  = 1'b1;
                        state_d = StAck;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (!req) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With zero wait states the access uses the live inputs on the capture edge.
    always_comb begin
        acc_idx   = capture ? Address[DEPTH_LOG2+1:2] : idx_q;
        acc_we    = capture ? WriteEnable : we_q;
        acc_wdata = capture ? MWriteData : wdata_q;
        acc_re    = capture ? ReadEnable : re_q;
        acc_oob   = capture ? in_oob : oob_q;
        rdata_d   = rdata_q;
        if (access) begin
            if (acc_oob) begin
                rdata_d = '0;
            end else if (acc_re) begin
                rdata_d = mem[acc_idx];
            end
        end
        MReadData   = rdata_q;
        DataMem_Ack = (state_q == StAck);
    end

    always_ff @(posedge CLK) begin
        if (!RST && access && !acc_oob) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_we[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_memory_wait.sv
// Directed bench for data_memory_wait: WAIT_STATES=2 instance via scoreboard, plus a
// zero-wait-state instance for back-to-back timing.
module tb_data_memory_wait;
    localparam int unsigned WS = 2;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic [31:0] Address, MWriteData, MReadData;
    logic [3:0]  WriteEnable;
    logic        ReadEnable, DataMem_Ack;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [3:0]  z_we;
    logic        z_re, z_ack;
`ifdef DMEM_RANGE_CHECK_EN
    logic        DataMem_Err, z_err;
`endif

    data_memory_wait #(.DEPTH_LOG2(10), .WAIT_STATES(WS), .INIT_FILE("")) u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .Address     (Address),
        .MWriteData  (MWriteData),
        .WriteEnable (WriteEnable),
        .ReadEnable  (ReadEnable),
        .MReadData   (MReadData),
`ifdef DMEM_RANGE_CHECK_EN
        .DataMem_Err (DataMem_Err),
`endif
        .DataMem_Ack (DataMem_Ack)
    );

    data_memory_wait #(.DEPTH_LOG2(10), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
        .CLK         (CLK),
        .RST         (RST),
        .Address     (z_addr),
        .MWriteData  (z_wdata),
        .WriteEnable (z_we),
        .ReadEnable  (z_re),
        .MReadData   (z_rdata),
`ifdef DMEM_RANGE_CHECK_EN
        .DataMem_Err (z_err),
`endif
        .DataMem_Ack (z_ack)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [1024];
    logic [31:0] cur_rd;
    int          checks = 0;
    int          errors = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic out_of_range(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
        return |a[31:12];
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    // One complete access on the WAIT_STATES=2 instance; expectation queued at drive time.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] wd, input logic re);
        exp_t       e;
        int         lat;
        logic [9:0] idx;
        idx = addr[11:2];
        @(negedge CLK);
        Address     = addr;
        WriteEnable = we;
        MWriteData  = wd;
        ReadEnable  = re;
        if (out_of_range(addr)) begin
            e.data = 32'h0;
            e.err  = 1'b1;
        end else begin
            e.err  = 1'b0;
            e.data = re ? model[idx] : cur_rd;
            for (int i = 0; i < 4; i++) begin
                if (we[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
            end
        end
        cur_rd = e.data;
        sb.push_back(e);
        @(posedge CLK);
        lat = 0;
        for (int k = 1; k <= int'(WS) + 6; k++) begin
            @(negedge CLK);
            if (DataMem_Ack === 1'b1) begin
                lat = k;
                break;
            end
        end
        check32({tag, "/latency"}, lat, WS + 1);
        e = sb.pop_front();
        check32({tag, "/rdata"}, MReadData, e.data);
`ifdef DMEM_RANGE_CHECK_EN
        check1({tag, "/err"}, DataMem_Err, e.err);
`endif
        Address     = '0;
        WriteEnable = '0;
        MWriteData  = '0;
        ReadEnable  = 1'b0;
        @(negedge CLK);
        check1({tag, "/ack_pulse"}, DataMem_Ack, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int acks;
        RST = 1'b1;
        Address = '0; MWriteData = '0; WriteEnable = '0; ReadEnable = 1'b0;
        z_addr = '0; z_wdata = '0; z_we = '0; z_re = 1'b0;
        cur_rd = '0;
        repeat (2) @(negedge CLK);
        check32("reset/rdata", MReadData, 32'h0);
        check1("reset/ack", DataMem_Ack, 1'b0);
        check32("reset/rdata0", z_rdata, 32'h0);
        check1("reset/ack0", z_ack, 1'b0);
`ifdef DMEM_RANGE_CHECK_EN
        check1("reset/err", DataMem_Err, 1'b0);
`endif
        RST = 1'b0;

        // Full word write and read back
        xfer("wr40", 32'h40, 4'hF, 32'hDEAD_BEEF, 1'b0);
        xfer("rd40", 32'h40, 4'h0, 32'h0, 1'b1);

        // Byte-lane merge
        xfer("pre80", 32'h80, 4'hF, 32'h1122_3344, 1'b0);
        xfer("lane80", 32'h80, 4'b0010, 32'hAAAA_AAAA, 1'b0);
        xfer("rd80", 32'h80, 4'h0, 32'h0, 1'b1);
        check32("lane_merge", MReadData, 32'h1122_AA44);

        // Abort: drop req in the second BUSY cycle
        xfer("pre100", 32'h100, 4'hF, 32'h0BAD_F00D, 1'b0);
        @(negedge CLK);
        Address = 32'h100; WriteEnable = 4'hF; MWriteData = 32'h55; ReadEnable = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        acks = (DataMem_Ack === 1'b1) ? 1 : 0;
        @(negedge CLK);
        Address = '0; WriteEnable = '0; MWriteData = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (DataMem_Ack === 1'b1) acks++;
        end
        check32("abort/no_ack", acks, 0);
        check32("abort/rdata_held", MReadData, cur_rd);
        xfer("rd100", 32'h100, 4'h0, 32'h0, 1'b1);

        // Reset while BUSY with a pending write
        @(negedge CLK);
        Address = 32'h40; WriteEnable = 4'hF; MWriteData = 32'h1234_5678;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        Address = '0; WriteEnable = '0; MWriteData = '0;
        @(negedge CLK);
        RST = 1'b0;
        cur_rd = '0;
        check1("rst_busy/ack", DataMem_Ack, 1'b0);
        check32("rst_busy/rdata", MReadData, 32'h0);
        xfer("rd40_post_rst", 32'h40, 4'h0, 32'h0, 1'b1);

        // Address above the array
        xfer("pre0", 32'h0, 4'hF, 32'h0102_0304, 1'b0);
        xfer("wr1000", 32'h1000, 4'hF, 32'hCAFE_F00D, 1'b0);
        xfer("rd0", 32'h0, 4'h0, 32'h0, 1'b1);
`ifdef DMEM_RANGE_CHECK_EN
        check32("range/word0_kept", MReadData, 32'h0102_0304);
`else
        check32("range/word0_alias", MReadData, 32'hCAFE_F00D);
`endif

        // Zero wait states: ack one edge after capture, back-to-back after one idle edge
        @(negedge CLK);
        z_addr = 32'h200; z_we = 4'hF; z_wdata = 32'hA5A5_A5A5;
        @(posedge CLK);
        @(negedge CLK);
        check1("ws0/wr200_ack", z_ack, 1'b1);
        z_addr = 32'h204; z_wdata = 32'h5A5A_0000;
        @(negedge CLK);
        check1("ws0/ack_drop", z_ack, 1'b0);
        @(negedge CLK);
        check1("ws0/wr204_ack", z_ack, 1'b1);
        z_we = '0; z_wdata = '0; z_addr = 32'h200; z_re = 1'b1;
        @(negedge CLK);
        check1("ws0/idle_gap", z_ack, 1'b0);
        @(negedge CLK);
        check1("ws0/rd200_ack", z_ack, 1'b1);
        check32("ws0/rd200_data", z_rdata, 32'hA5A5_A5A5);
        z_addr = 32'h204;
        @(negedge CLK);
        check1("ws0/single_pulse", z_ack, 1'b0);
        check32("ws0/data_held", z_rdata, 32'hA5A5_A5A5);
        @(negedge CLK);
        check1("ws0/rd204_ack", z_ack, 1'b1);
        check32("ws0/rd204_data", z_rdata, 32'h5A5A_0000);
        z_re = 1'b0; z_addr = '0;
        @(negedge CLK);
        check1("ws0/final_drop", z_ack, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
